// File: rtl/game_score_ctrl_pkg.sv
// game_score_ctrl_pkg: shared FSM state encodings, winner codes and saturating score increment
package game_score_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_OVER = 2'd2} state_t;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1 = 2'b01;
  localparam logic [1:0] WIN_P2 = 2'b10;
  function automatic logic [7:0] sat_inc(input logic [7:0] s, input logic [7:0] max);
    return (s >= max) ? max : s + 8'd1;
  endfunction
endpackage

// File: rtl/game_score_ctrl_hit_holdoff.sv
// hit_holdoff: per-player hit edge detect + frame-based holdoff; count pulses when a hit is accepted
//   clk, rst (async active-low), hit (level), frame_tick, en (scoring allowed), clr (new game) -> count
module hit_holdoff #(
  parameter int HOLDOFF_FRAMES = 30,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic hit,
  input  logic frame_tick,
  input  logic en,
  input  logic clr,
  output logic count
);
  logic hit_q, h_p;
  logic [CNT_W-1:0] hold;
  assign count = h_p & en & (hold == '0);
  // reload wins over the frame-tick decrement
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hit_q <= 1'b0;
      h_p <= 1'b0;
      hold <= '0;
    end else begin
      hit_q <= hit;
      h_p <= hit & ~hit_q;
      hold <= clr ? '0 :
              count ? CNT_W'(HOLDOFF_FRAMES) :
              (frame_tick && hold != '0) ? hold - CNT_W'(1) : hold;
    end
endmodule

// File: rtl/game_score_ctrl.sv
// game_score_ctrl: IDLE/RUN/OVER game flow, saturating scores, HUD timer reset pulse and winner
//   in: clk, rst (async active-low), vsync_in, start (async), NoOfPlayers, P1Hit, P2Hit, TimeOut
//   out: Player1Score, Player2Score, bg_rst_n, game_over, winner, running
module game_score_ctrl
  import game_score_ctrl_pkg::*;
#(
  parameter int MAX_SCORE = 99,
  parameter int HOLDOFF_FRAMES = 30,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       start,
  input  logic       NoOfPlayers,
  input  logic       P1Hit,
  input  logic       P2Hit,
  input  logic       TimeOut,
  output logic [7:0] Player1Score,
  output logic [7:0] Player2Score,
  output logic       bg_rst_n,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       running
);
  state_t state, state_nxt;
  logic [2:0] s_sync;
  logic start_p, v_q, frame_tick, np_q, start_go, to_over, en, cnt1, cnt2;
  logic [1:0] blank, win_nxt;
  assign running = state == ST_RUN;
  assign game_over = state == ST_OVER;
  assign start_go = start_p & ~running;
  // the HUD's TimeOut is still clearing during the first two RUN cycles
  assign to_over = running & (blank == 2'd0) & TimeOut;
  assign en = running & ~to_over;
  always_comb begin
    state_nxt = start_go ? ST_RUN : to_over ? ST_OVER : state;
    win_nxt = !np_q ? WIN_P1 :
              (Player1Score > Player2Score) ? WIN_P1 :
              (Player2Score > Player1Score) ? WIN_P2 : WIN_NONE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s_sync <= 3'b000;
      start_p <= 1'b0;
      v_q <= 1'b0;
      frame_tick <= 1'b0;
      bg_rst_n <= 1'b1;
      np_q <= 1'b0;
      blank <= 2'd0;
      Player1Score <= 8'd0;
      Player2Score <= 8'd0;
      winner <= WIN_NONE;
    end else begin
      s_sync <= {s_sync[1:0], start};
      start_p <= s_sync[1] & ~s_sync[2];
      v_q <= vsync_in;
      frame_tick <= vsync_in & ~v_q;
      bg_rst_n <= ~start_go;
      if (start_go) begin
        np_q <= NoOfPlayers;
        blank <= 2'd2;
        Player1Score <= 8'd0;
        Player2Score <= 8'd0;
        winner <= WIN_NONE;
      end else begin
        if (running && blank != 2'd0) blank <= blank - 2'd1;
        if (cnt1) Player1Score <= sat_inc(Player1Score, 8'(MAX_SCORE));
        if (cnt2) Player2Score <= sat_inc(Player2Score, 8'(MAX_SCORE));
        if (to_over) winner <= win_nxt;
      end
    end
  hit_holdoff #(.HOLDOFF_FRAMES(HOLDOFF_FRAMES), .CNT_W(CNT_W)) u_h1 (
    .clk(clk), .rst(rst), .hit(P1Hit), .frame_tick(frame_tick),
    .en(en), .clr(start_go), .count(cnt1)
  );
  hit_holdoff #(.HOLDOFF_FRAMES(HOLDOFF_FRAMES), .CNT_W(CNT_W)) u_h2 (
    .clk(clk), .rst(rst), .hit(P2Hit), .frame_tick(frame_tick),
    .en(en & np_q), .clr(start_go), .count(cnt2)
  );
endmodule

// File: tb/tb_game_score_ctrl.sv
// tb_game_score_ctrl: table-driven + scoreboard self-checking bench for game_score_ctrl
module tb_game_score_ctrl;
  import game_score_ctrl_pkg::*;
  logic clk = 0, rst = 0, vsync_in = 0, start = 0, NoOfPlayers = 0;
  logic P1Hit = 0, P2Hit = 0, TimeOut = 0;
  logic [7:0] Player1Score, Player2Score;
  logic bg_rst_n, game_over, running;
  logic [1:0] winner;
  int tests = 0, fails = 0;
  typedef struct {
    string name;
    logic h1, h2;
    int ticks, hold;
    logic [7:0] e1, e2;
  } vec_t;
  typedef struct {
    string name;
    logic [7:0] e1, e2;
  } exp_t;
  exp_t sb[$];
  vec_t v[6];
  always #5 clk = ~clk;
  game_score_ctrl dut (
    .clk(clk), .rst(rst), .vsync_in(vsync_in), .start(start), .NoOfPlayers(NoOfPlayers),
    .P1Hit(P1Hit), .P2Hit(P2Hit), .TimeOut(TimeOut), .Player1Score(Player1Score),
    .Player2Score(Player2Score), .bg_rst_n(bg_rst_n), .game_over(game_over),
    .winner(winner), .running(running)
  );
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic frames(input int n);
    repeat (n) begin
      vsync_in = 1;
      cyc(2);
      vsync_in = 0;
      cyc(2);
    end
  endtask
  task automatic hit(input logic a, input logic b, input int hold);
    P1Hit = a;
    P2Hit = b;
    cyc(hold);
    P1Hit = 0;
    P2Hit = 0;
    cyc(3);
  endtask
  task automatic push(input string nm, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.name = nm;
    e.e1 = a;
    e.e2 = b;
    sb.push_back(e);
  endtask
  task automatic pop_check;
    exp_t e;
    if (sb.size() == 0) chk("scoreboard_empty", 1, 0);
    else begin
      e = sb.pop_front();
      chk({e.name, "_p1"}, Player1Score, e.e1);
      chk({e.name, "_p2"}, Player2Score, e.e2);
    end
  endtask
  // start held 5 clk; TimeOut (if high) is dropped two cycles after the bg pulse to probe blanking
  task automatic start_game(input logic np, output int lows, output int first);
    start = 1;
    NoOfPlayers = np;
    lows = 0;
    first = -1;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      if (i == 5) start = 0;
      if (!bg_rst_n) begin
        lows++;
        if (first < 0) first = i;
      end
      if (first >= 0 && i == first + 2) TimeOut = 0;
    end
  endtask
  initial begin
    int lows, first, c1, c2;
    logic [7:0] p1o, p2o;
    v[0] = '{"p1_held", 1, 0, 0, 100, 1, 0};
    v[1] = '{"p1_in_holdoff", 1, 0, 10, 3, 1, 0};
    v[2] = '{"p1_after_30", 1, 0, 25, 3, 2, 0};
    v[3] = '{"p2_first", 0, 1, 0, 3, 2, 1};
    v[4] = '{"both", 1, 1, 31, 3, 3, 2};
    v[5] = '{"p2_in_holdoff", 0, 1, 5, 3, 3, 2};
    cyc(2);
    chk("rst_p1", Player1Score, 0);
    chk("rst_p2", Player2Score, 0);
    chk("rst_bg", bg_rst_n, 1);
    chk("rst_over", game_over, 0);
    chk("rst_win", winner, WIN_NONE);
    chk("rst_run", running, 0);
    rst = 1;
    cyc(2);
    start_game(1, lows, first);
    chk("start_bg_lows", lows, 1);
    chk("start_bg_when", first, 4);
    chk("start_running", running, 1);
    chk("start_p1", Player1Score, 0);
    chk("start_p2", Player2Score, 0);
    for (int i = 0; i < 6; i++) begin
      frames(v[i].ticks);
      push(v[i].name, v[i].e1, v[i].e2);
      hit(v[i].h1, v[i].h2, v[i].hold);
      pop_check();
    end
    frames(31);
    p1o = Player1Score;
    p2o = Player2Score;
    c1 = -1;
    c2 = -1;
    P1Hit = 1;
    P2Hit = 1;
    for (int i = 1; i <= 6; i++) begin
      cyc(1);
      if (c1 < 0 && Player1Score != p1o) c1 = i;
      if (c2 < 0 && Player2Score != p2o) c2 = i;
    end
    P1Hit = 0;
    P2Hit = 0;
    chk("same_cycle_p1_seen", c1 > 0, 1);
    chk("same_cycle_equal", c1, c2);
    chk("same_cycle_p1", Player1Score, 4);
    chk("same_cycle_p2", Player2Score, 3);
    start_game(1, lows, first);
    chk("start_in_run_bg", lows, 0);
    chk("start_in_run_p1", Player1Score, 4);
    chk("start_in_run_run", running, 1);
    TimeOut = 1;
    cyc(1);
    chk("over_4_3_flag", game_over, 1);
    chk("over_4_3_win", winner, WIN_P1);
    chk("over_4_3_run", running, 0);
    frames(31);
    hit(1, 1, 3);
    chk("over_frozen_p1", Player1Score, 4);
    chk("over_frozen_p2", Player2Score, 3);
    start_game(1, lows, first);
    chk("restart_bg_lows", lows, 1);
    chk("restart_blank_run", running, 1);
    chk("restart_p1", Player1Score, 0);
    for (int i = 0; i < 5; i++) begin
      frames(31);
      hit(i < 3, 1, 3);
    end
    chk("pre_over_p1", Player1Score, 3);
    chk("pre_over_p2", Player2Score, 5);
    TimeOut = 1;
    cyc(1);
    chk("over_3_5_flag", game_over, 1);
    chk("over_3_5_win", winner, WIN_P2);
    start_game(0, lows, first);
    chk("np0_bg_lows", lows, 1);
    for (int k = 1; k <= 101; k++) begin
      frames(31);
      push($sformatf("sat_%0d", k), (k > 99) ? 8'd99 : 8'(k), 8'd0);
      hit(1, 1, 1);
      pop_check();
    end
    TimeOut = 1;
    cyc(1);
    chk("np0_win", winner, WIN_P1);
    start_game(1, lows, first);
    hit(1, 0, 3);
    chk("pre_async_p1", Player1Score, 1);
    #2 rst = 0;
    #1;
    chk("async_p1", Player1Score, 0);
    chk("async_run", running, 0);
    chk("async_bg", bg_rst_n, 1);
    chk("async_win", winner, WIN_NONE);
    @(negedge clk);
    rst = 1;
    TimeOut = 1;
    cyc(5);
    chk("idle_timeout_over", game_over, 0);
    chk("idle_timeout_run", running, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
